// File: rtl/sal_ref_ctrl_pkg.sv
// Shared refresh-controller definitions: channel-level timing widths, the
// refresh debt ceiling, the refresh FSM state type and the state-to-output
// decode used by the controller.
package sal_ref_ctrl_pkg;

    localparam int DRAM_BK_CNT      = 16;
    localparam int T_REFI_WIDTH     = 16;
    localparam int T_RFC_WIDTH      = 10;
    localparam int REF_MAX_POSTPONE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REQ   = 2'd2,
        RFC   = 2'd3
    } ref_state_t;

    // Moore decode of the refresh state into {ref_pend, ref_req, ref_busy}.
    // Pending covers every non-idle state so the banks stay closed from the
    // start of the drain until the tRFC window finally releases them.
    function automatic logic [2:0] ref_out_decode(input ref_state_t st);
        logic [2:0] out_v;
        case (st)
            IDLE:    out_v = 3'b000;
            DRAIN:   out_v = 3'b100;
            REQ:     out_v = 3'b110;
            RFC:     out_v = 3'b101;
            default: out_v = 3'b000;
        endcase
        return out_v;
    endfunction

endpackage

// File: rtl/sal_ref_tick_gen.sv
// tREFI interval generator: a reloadable down-counter that advances only
// while enabled and emits a registered one-cycle tick every load_val_i+1
// enabled cycles. The counter starts from load_val_i out of reset.
module sal_ref_tick_gen
    import sal_ref_ctrl_pkg::*;
#(
    parameter int REFI_W = T_REFI_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [REFI_W-1:0] load_val_i,
    output logic              tick_o
);

    localparam logic [REFI_W-1:0] CNT_ZERO = {REFI_W{1'b0}};
    localparam logic [REFI_W-1:0] CNT_ONE  = REFI_W'(1'b1);

    logic [REFI_W-1:0] cnt_q;
    logic [REFI_W-1:0] cnt_d;
    logic              tick_q;
    logic              tick_d;

    // Next count and tick: hold while disabled, reload and tick on expiry.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en_i) begin
            if (cnt_q == CNT_ZERO) begin
                cnt_d  = load_val_i;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q - CNT_ONE;
                tick_d = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= load_val_i;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sal_ref_ctrl.sv
// All-bank refresh controller. Accumulates refresh debt from the tREFI tick,
// postpones refreshes while traffic is pending (up to MAX_POSTPONE), then
// drains the banks, requests the REF slot and holds the banks off for tRFC.
// Back-to-back refreshes are pulled in directly from the tRFC window while
// debt remains and the channel is quiet (or the debt ceiling is reached).
module sal_ref_ctrl
    import sal_ref_ctrl_pkg::*;
#(
    parameter int BK_CNT       = DRAM_BK_CNT,
    parameter int REFI_W       = T_REFI_WIDTH,
    parameter int RFC_W        = T_RFC_WIDTH,
    parameter int MAX_POSTPONE = REF_MAX_POSTPONE
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ref_en_i,
    input  logic [REFI_W-1:0]                      t_refi_m1_i,
    input  logic [RFC_W-1:0]                       t_rfc_m1_i,
    input  logic                                   traffic_i,
    input  logic [BK_CNT-1:0]                      bk_idle_i,
    input  logic                                   ref_gnt_i,
    output logic                                   ref_pend_o,
    output logic                                   ref_req_o,
    output logic                                   ref_busy_o,
    output logic [$clog2(MAX_POSTPONE+1)-1:0]      debt_o,
    output logic                                   err_o
);

    localparam int DEBT_W = $clog2(MAX_POSTPONE + 1);

    localparam logic [DEBT_W-1:0] DEBT_ZERO = {DEBT_W{1'b0}};
    localparam logic [DEBT_W-1:0] DEBT_ONE  = DEBT_W'(1'b1);
    localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_POSTPONE);
    localparam logic [RFC_W-1:0]  RFC_ZERO  = {RFC_W{1'b0}};
    localparam logic [RFC_W-1:0]  RFC_ONE   = RFC_W'(1'b1);

    logic              tick_s;
    logic              gnt_acc_s;
    logic              due_s;
    logic              all_idle_s;

    ref_state_t        state_q;
    ref_state_t        state_d;
    logic [DEBT_W-1:0] debt_q;
    logic [DEBT_W-1:0] debt_d;
    logic              err_q;
    logic              err_d;
    logic [RFC_W-1:0]  rfc_cnt_q;
    logic [RFC_W-1:0]  rfc_cnt_d;
    logic              ref_pend_q;
    logic              ref_pend_d;
    logic              ref_req_q;
    logic              ref_req_d;
    logic              ref_busy_q;
    logic              ref_busy_d;

    sal_ref_tick_gen #(
        .REFI_W (REFI_W)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ref_en_i),
        .load_val_i (t_refi_m1_i),
        .tick_o     (tick_s)
    );

    // A grant only counts while the request is actually being presented.
    assign gnt_acc_s  = ref_req_q & ref_gnt_i;
    assign all_idle_s = &bk_idle_i;

    // Debt bookkeeping: tick adds, accepted grant subtracts, both cancel.
    // A tick that would exceed the ceiling is dropped and flagged sticky.
    always_comb begin
        debt_d = debt_q;
        err_d  = err_q;
        if (tick_s && !gnt_acc_s) begin
            if (debt_q == DEBT_MAX) begin
                err_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_ONE;
            end
        end else if (gnt_acc_s && !tick_s) begin
            if (debt_q != DEBT_ZERO) begin
                debt_d = debt_q - DEBT_ONE;
            end else begin
                debt_d = debt_q;
            end
        end else begin
            debt_d = debt_q;
        end
    end

    // Refresh is due on the post-update debt, so a tick starts the drain
    // on the very next cycle; a full debt overrides pending traffic.
    always_comb begin
        if ((debt_d != DEBT_ZERO) && ref_en_i && (!traffic_i || (debt_d == DEBT_MAX))) begin
            due_s = 1'b1;
        end else begin
            due_s = 1'b0;
        end
    end

    // Next-state logic for the refresh sequence and the tRFC counter.
    // A grant in REQ wins over a simultaneous disable: once the scheduler
    // has issued REF the tRFC window must be honoured.
    always_comb begin
        state_d   = state_q;
        rfc_cnt_d = rfc_cnt_q;
        case (state_q)
            IDLE: begin
                if (due_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!ref_en_i) begin
                    state_d = IDLE;
                end else if (all_idle_s) begin
                    state_d = REQ;
                end else begin
                    state_d = DRAIN;
                end
            end
            REQ: begin
                if (ref_gnt_i) begin
                    state_d   = RFC;
                    rfc_cnt_d = t_rfc_m1_i;
                end else if (!ref_en_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            RFC: begin
                if (rfc_cnt_q == RFC_ZERO) begin
                    if (due_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d   = RFC;
                    rfc_cnt_d = rfc_cnt_q - RFC_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                rfc_cnt_d = RFC_ZERO;
            end
        endcase
    end

    // Output registers load the decode of the next state, so each output
    // equals a pure decode of the current state register.
    always_comb begin
        {ref_pend_d, ref_req_d, ref_busy_d} = ref_out_decode(state_d);
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            debt_q     <= DEBT_ZERO;
            err_q      <= 1'b0;
            rfc_cnt_q  <= RFC_ZERO;
            ref_pend_q <= 1'b0;
            ref_req_q  <= 1'b0;
            ref_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            debt_q     <= debt_d;
            err_q      <= err_d;
            rfc_cnt_q  <= rfc_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_req_q  <= ref_req_d;
            ref_busy_q <= ref_busy_d;
        end
    end

    assign ref_pend_o = ref_pend_q;
    assign ref_req_o  = ref_req_q;
    assign ref_busy_o = ref_busy_q;
    assign debt_o     = debt_q;
    assign err_o      = err_q;

endmodule
